// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
//   shift_type_e : operation class carried with each operation
//   SH_LEFT/RIGHT: direction encoding of in_dir
//   WORD_W       : width of the RV64 *W word operations
//   shift_ctrl_t : mode bits that travel down the pipeline with the data
// No ports (package).
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LOGIC = 2'b00,
        SH_ARITH = 2'b01,
        SH_ROT   = 2'b10
    } shift_type_e;

    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    localparam int WORD_W = 32;

    typedef struct packed {
        shift_type_e typ;
        logic        dir;
        logic        word;
    } shift_ctrl_t;

endpackage

// File: rtl/shifter_pipe_if.sv
// Operation/result bus of shifter_pipe.
//   in_valid/in_ready   : operation handshake (in_ready driven by the shifter)
//   in_a, in_shift      : operand and shift distance
//   in_type/dir/word    : operation mode
//   in_tag              : opaque tag returned with the result
//   out_valid/out_ready : result handshake (out_ready driven by the consumer)
//   out_y, out_tag      : result and its tag
// master = producer/consumer side, slave = shifter side.
interface shifter_pipe_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = $clog2(WIDTH),
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [DEPTH-1:0] in_shift;
    logic [1:0]       in_type;
    logic             in_dir;
    logic             in_word;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_shift, in_type, in_dir, in_word, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_shift, in_type, in_dir, in_word, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag
    );
endinterface

// File: rtl/shifter_stage.sv
// One combinational barrel stage: right shift by the fixed distance SHAMT
// when en is set, otherwise pass data through.
//   data : stage input      en   : apply this stage's distance
//   typ  : logical/arith/rotate fill
//   word : operate on the low WORD_W bits only (upper bits don't care)
//   y    : stage output
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHAMT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  shift_type_e      typ,
    input  logic             word,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] full_y;
    logic [WIDTH-1:0] word_y;

    always_comb begin
        case (typ)
            SH_ROT:   full_y = {data[SHAMT-1:0], data[WIDTH-1:SHAMT]};
            SH_ARITH: full_y = {{SHAMT{data[WIDTH-1]}}, data[WIDTH-1:SHAMT]};
            default:  full_y = {{SHAMT{1'b0}}, data[WIDTH-1:SHAMT]};
        endcase
    end

    generate
        if (SHAMT < WORD_W) begin : g_word
            // Word ops shift/rotate inside bits [31:0]; upper bits are
            // replaced by the sign extension at the pipeline exit.
            always_comb begin
                word_y = data;
                case (typ)
                    SH_ROT:   word_y[WORD_W-1:0] = {data[SHAMT-1:0], data[WORD_W-1:SHAMT]};
                    SH_ARITH: word_y[WORD_W-1:0] = {{SHAMT{data[WORD_W-1]}}, data[WORD_W-1:SHAMT]};
                    default:  word_y[WORD_W-1:0] = {{SHAMT{1'b0}}, data[WORD_W-1:SHAMT]};
                endcase
            end
        end else begin : g_noword
            // Never enabled for word ops; the top masks this distance.
            assign word_y = data;
        end
    endgenerate

    assign y = !en ? data : (word ? word_y : full_y);

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined RV64/Zbb barrel shifter: SLL/SRL/SRA/ROL/ROR and their *W forms.
// A register follows every REG_EVERY barrel stages; the last register is the
// output register. Global stall: the whole pipe holds when the output is
// valid and not taken. Left shifts are done as right shifts on bit-reversed
// data (reversed again at the exit).
//   clk   : clock              rst_n : synchronous active-low reset
//   flush : kills all in-flight operations at the next edge
//   bus   : operation/result bus (shifter_pipe_if.slave)
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = $clog2(WIDTH),
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    shifter_pipe_if.slave  bus
);
    localparam int LAT = (DEPTH + REG_EVERY - 1) / REG_EVERY;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [DEPTH-1:0] shamt;
        shift_ctrl_t      ctrl;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic logic [WIDTH-1:0] rev_bits(input logic [WIDTH-1:0] d, input logic word);
        logic [WIDTH-1:0] r;
        r = '0;
        if (word) begin
            for (int i = 0; i < WORD_W; i++) r[i] = d[WORD_W-1-i];
        end else begin
            for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] finish_result(input logic [WIDTH-1:0] d, input shift_ctrl_t c);
        logic [WIDTH-1:0] r;
        r = (c.dir == SH_LEFT) ? rev_bits(d, c.word) : d;
        if (c.word) begin
            for (int i = WORD_W; i < WIDTH; i++) r[i] = r[WORD_W-1];
        end
        return r;
    endfunction

    stage_t           entry_p0;
    stage_t           grp_src [LAT];
    stage_t           next_p  [LAT];
    stage_t           stage_p [LAT];
    logic [LAT-1:0]   vld_p;
    logic [WIDTH-1:0] s_in  [DEPTH];
    logic [WIDTH-1:0] s_out [DEPTH];
    logic [DEPTH-1:0] s_en;
    logic             adv;
    logic             unused_bits;

    assign adv           = !vld_p[LAT-1] || bus.out_ready;
    assign bus.in_ready  = adv && !flush;
    assign bus.out_valid = vld_p[LAT-1];
    assign bus.out_y     = stage_p[LAT-1].data;
    assign bus.out_tag   = stage_p[LAT-1].tag;

    // ---- entry: normalise mode, reverse operand for left shifts ----
    always_comb begin
        entry_p0.data      = (bus.in_dir == SH_LEFT) ? rev_bits(bus.in_a, bus.in_word) : bus.in_a;
        entry_p0.shamt     = bus.in_shift;
        entry_p0.ctrl.dir  = bus.in_dir;
        entry_p0.ctrl.word = bus.in_word;
        entry_p0.tag       = bus.in_tag;
        // Type 11 acts as logical; a left arithmetic shift is a logical one.
        entry_p0.ctrl.typ  = SH_LOGIC;
        if (bus.in_type == SH_ROT)
            entry_p0.ctrl.typ = SH_ROT;
        else if (bus.in_type == SH_ARITH && bus.in_dir == SH_RIGHT)
            entry_p0.ctrl.typ = SH_ARITH;
    end

    assign grp_src[0] = entry_p0;

    generate
        for (genvar g = 1; g < LAT; g++) begin : g_src
            assign grp_src[g] = stage_p[g-1];
        end

        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            localparam int G = s / REG_EVERY;
            if (s % REG_EVERY == 0) begin : g_head
                assign s_in[s] = grp_src[G].data;
            end else begin : g_body
                assign s_in[s] = s_out[s-1];
            end
            // Distances of 32 and up are meaningless for word ops.
            if ((1 << s) >= WORD_W) begin : g_en_word
                assign s_en[s] = grp_src[G].shamt[s] && !grp_src[G].ctrl.word;
            end else begin : g_en_full
                assign s_en[s] = grp_src[G].shamt[s];
            end
            shifter_stage #(
                .WIDTH (WIDTH),
                .SHAMT (1 << s)
            ) u_stage (
                .data (s_in[s]),
                .en   (s_en[s]),
                .typ  (grp_src[G].ctrl.typ),
                .word (grp_src[G].ctrl.word),
                .y    (s_out[s])
            );
        end

        for (genvar g = 0; g < LAT; g++) begin : g_next
            localparam int LAST = ((((g + 1) * REG_EVERY) < DEPTH) ? ((g + 1) * REG_EVERY) : DEPTH) - 1;
            if (g == LAT - 1) begin : g_out
                assign next_p[g] = {finish_result(s_out[LAST], grp_src[g].ctrl),
                                    grp_src[g].shamt, grp_src[g].ctrl, grp_src[g].tag};
            end else begin : g_mid
                assign next_p[g] = {s_out[LAST], grp_src[g].shamt, grp_src[g].ctrl, grp_src[g].tag};
            end
        end
    endgenerate

    // ---- pipeline registers p0 .. p(LAT-1); the last is the output ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int r = 0; r < LAT; r++) stage_p[r] <= '0;
        end else begin
            if (flush) begin
                vld_p <= '0;
            end else if (adv) begin
                vld_p[0] <= bus.in_valid;
                for (int r = 1; r < LAT; r++) vld_p[r] <= vld_p[r-1];
            end
            if (adv) begin
                for (int r = 0; r < LAT; r++) stage_p[r] <= next_p[r];
            end
        end
    end

    // Distance bits already consumed and the output's mode bits go nowhere.
    always_comb begin
        unused_bits = ^{stage_p[LAT-1].shamt, stage_p[LAT-1].ctrl};
        for (int r = 0; r < LAT - 1; r++) unused_bits = unused_bits ^ (^stage_p[r].shamt);
    end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Pipelined, parametrised successor to the combinational barrel shifter; sits in the ALU execute path for RV64 plus Zbb.
- Performs logical left/right, arithmetic right, and rotate left/right, in full-width or 32-bit word mode (SLLW/SRLW/SRAW/ROLW/RORW).
- Pipeline registers are inserted every REG_EVERY barrel stages.
- Has a valid/ready handshake with backpressure, an opaque tag passthrough, and a synchronous flush.

Parameters:
WIDTH, 64, operand/result width; power of two, >= 32 (word mode requires WIDTH == 64)
DEPTH, $clog2(WIDTH), number of barrel stages (shift distances 1, 2, 4 ... WIDTH/2)
REG_EVERY, 2, barrel stages per pipeline register; 1..DEPTH
TAG_W, 5, width of tag carried alongside each operation
LAT, (DEPTH+REG_EVERY-1)/REG_EVERY, derived latency in cycles; not to be overridden

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous kill of all in-flight operations
in_valid  in  1  operation presented
in_ready  out  1  block accepts operation this cycle
in_a  in  WIDTH  operand
in_shift  in  DEPTH  shift distance
in_type  in  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
in_dir  in  1  0 left, 1 right
in_word  in  1  1 = 32-bit word operation
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_y  out  WIDTH  result
out_tag  out  TAG_W  tag of result

Behaviour:
- Reset (rst_n == 0 at clk edge) clears state:
  - all stage valid bits = 0, out_y = 0, out_tag = 0, all intermediate data registers = 0.
  - in_ready reads 1 once rst_n is released.
- Accept: an operation is accepted when in_valid && in_ready, sampled on the clk edge.
- Latency: result appears at out_valid exactly LAT cycles after acceptance when there is no stall (WIDTH = 64, REG_EVERY = 2: LAT = 3).
- Pipeline structure:
  - Registers after barrel stages REG_EVERY, 2·REG_EVERY, …, DEPTH.
  - The last register is the output register; out_y and out_tag come straight from flops.
- Stall model, global:
  - adv = !out_valid || out_ready.
  - in_ready = adv && !flush.
  - When adv == 0, every stage holds data, tag and valid; out_y and out_tag must remain stable while out_valid && !out_ready.
- Bubbles advance normally when adv == 1; a valid slot never overwrites another valid slot.
- Ordering: results leave in acceptance order. There is no reordering and no drop except on flush.
- Flush:
  - At the next edge, all valid bits = 0; data registers need not clear.
  - An in_valid in the flush cycle is not accepted (in_ready = 0).
  - Flush overrides stall.
  - rst_n has priority over flush.
- Shift semantics, full width (in_word = 0):
  - Distance = in_shift (0 .. WIDTH-1).
  - Left arithmetic = left logical.
  - Rotate left by n is the inverse of rotate right by n.
  - Shift 0 returns in_a unchanged for every type and direction.
- Word mode (in_word = 1):
  - in_shift[DEPTH-1] is ignored; distance = in_shift[4:0].
  - Only in_a[31:0] is operated on; bits above 31 of in_a have no effect on the result.
  - The 32-bit result is sign-extended from bit 31 to WIDTH (for all types, including logical right and rotate, per RV64 *W semantics).
  - Arithmetic right fills from in_a[31]; rotates wrap within 32 bits.
- Mode controls (type, dir, word) travel with the data through the pipeline registers. A new mode may be accepted every cycle.
- The left shift is implemented by reversing on entry and reversing on exit around the right-shift barrel. Reversal is combinational and adds no cycles.
- Throughput: 1 operation per cycle when out_ready is held 1.

Decomposition:
- Package shifter_pkg holds:
  - shift_type_e: SH_LOGIC = 2'b00, SH_ARITH = 2'b01, SH_ROT = 2'b10.
  - Direction constants SH_LEFT = 1'b0, SH_RIGHT = 1'b1.
  - WORD_W = 32.
  - A packed struct for per-stage payload {data, type, dir, word, tag}.
- Sub-module shifter_stage, parameters WIDTH and SHAMT:
  - Inputs: data, enable bit, type, word.
  - Output: data shifted right by SHAMT or passed through.
  - Purely combinational, instantiated DEPTH times via generate.
- Pipeline registers stay in shifter_pipe.

Test Plan:
1. SRA: a = 0x8000_0000_0000_0000, shift = 4, type = 01, dir = 1 -> out_y = 0xF800_0000_0000_0000, out_valid exactly 3 cycles after accept.
2. ROL: a = 0x8000_0000_0000_0001, shift = 4, type = 10, dir = 0 -> 0x0000_0000_0000_0018. SLL of the same operand -> 0x0000_0000_0000_0010.
3. Word mode:
   - SLLW a = 0xDEAD_BEEF_4000_0001, shift = 1 -> 0xFFFF_FFFF_8000_0002.
   - RORW a = 0x0000_0000_0000_0001, shift = 33 (bit 5 ignored) -> 0xFFFF_FFFF_8000_0000.
   - SRAW a = 0x8000_0000, shift = 31 -> 0xFFFF_FFFF_FFFF_FFFF.
4. Backpressure:
   - Stimulus: 6 back-to-back ops with tags 0..5; out_ready = 0 for 4 cycles once the first result appears.
   - Required: in_ready = 0 while stalled; out_y/out_tag stable; afterwards tags 0..5 emerge in order with correct data; no loss or duplication.
5. Flush: 3 ops in flight plus in_valid = 1 during flush -> the next cycle out_valid = 0, none of the 4 ever emerges; a new op issued after flush returns normally in 3 cycles.
6. Reset: rst_n = 0 for 1 cycle with a full pipeline and out_ready = 0 -> next cycle out_valid = 0, out_y = 0, out_tag = 0, in_ready = 1.
   - Also: shift = 0 for all 6 type/dir combinations returns in_a unchanged.
